// File: rtl/y86_pkg.sv
// Shared Y86-64 encodings for the execute stage: instruction codes, status codes, ALU and condition functions.
// EXEC_MULQ_EN widens the legal OPq function range to include mulq.
package y86_pkg;

   localparam logic [3:0] IHALT   = 4'h0;
   localparam logic [3:0] INOP    = 4'h1;
   localparam logic [3:0] IRRMOVQ = 4'h2;
   localparam logic [3:0] IIRMOVQ = 4'h3;
   localparam logic [3:0] IRMMOVQ = 4'h4;
   localparam logic [3:0] IMRMOVQ = 4'h5;
   localparam logic [3:0] IOPQ    = 4'h6;
   localparam logic [3:0] IJXX    = 4'h7;
   localparam logic [3:0] ICALL   = 4'h8;
   localparam logic [3:0] IRET    = 4'h9;
   localparam logic [3:0] IPUSHQ  = 4'hA;
   localparam logic [3:0] IPOPQ   = 4'hB;

   localparam logic [2:0] STAT_AOK = 3'd1;
   localparam logic [2:0] STAT_HLT = 3'd2;
   localparam logic [2:0] STAT_ADR = 3'd3;
   localparam logic [2:0] STAT_INS = 3'd4;

   localparam logic [3:0] RNONE    = 4'hF;
   localparam logic [2:0] CC_RESET = 3'b100;

   typedef enum logic [3:0] {
      ALU_ADD = 4'h0,
      ALU_SUB = 4'h1,
      ALU_AND = 4'h2,
      ALU_XOR = 4'h3,
      ALU_MUL = 4'h4
   } alu_fun_t;

   typedef enum logic [3:0] {
      C_YES = 4'h0,
      C_LE  = 4'h1,
      C_L   = 4'h2,
      C_E   = 4'h3,
      C_NE  = 4'h4,
      C_GE  = 4'h5,
      C_G   = 4'h6
   } cond_t;

`ifdef EXEC_MULQ_EN
   localparam logic [3:0] MAX_OPQ_FUN = 4'd4;
`else
   localparam logic [3:0] MAX_OPQ_FUN = 4'd3;
`endif

endpackage

// File: rtl/y86_alu.sv
// Combinational Y86-64 ALU: res = b OP a with ZF/SF/OF.
// EXEC_MULQ_EN adds signed multiply; OF flags a product that overflows W signed bits.
module y86_alu
   import y86_pkg::*;
#(
   parameter int W = 64
) (
   input  logic [W-1:0] alu_a,
   input  logic [W-1:0] alu_b,
   input  alu_fun_t     fun,
   output logic [W-1:0] res,
   output logic         zf,
   output logic         sf,
   output logic         of
);

`ifdef EXEC_MULQ_EN
   logic signed [2*W-1:0] prod;
   assign prod = $signed({{W{alu_a[W-1]}}, alu_a}) * $signed({{W{alu_b[W-1]}}, alu_b});
`endif

   always_comb begin
      res = '0;
      of  = 1'b0;
      case (fun)
         ALU_ADD: begin
            res = alu_b + alu_a;
            of  = (alu_a[W-1] == alu_b[W-1]) && (res[W-1] != alu_a[W-1]);
         end
         ALU_SUB: begin
            res = alu_b - alu_a;
            of  = (alu_a[W-1] != alu_b[W-1]) && (res[W-1] != alu_b[W-1]);
         end
         ALU_AND: res = alu_b & alu_a;
         ALU_XOR: res = alu_b ^ alu_a;
`ifdef EXEC_MULQ_EN
         ALU_MUL: begin
            res = prod[W-1:0];
            // fits only if the upper half is a pure sign extension of bit W-1
            of  = !((&prod[2*W-1:W-1]) || !(|prod[2*W-1:W-1]));
         end
`endif
         default: res = '0;
      endcase
      zf = (res == '0);
      sf = res[W-1];
   end

endmodule

// File: rtl/execute_stage.sv
// Y86-64 execute stage: E pipeline register, ALU, condition codes and M pipeline register.
// EXEC_MULQ_EN enables OPq iFun 4 (mulq); otherwise that code traps as INS.
module execute_stage
   import y86_pkg::*;
#(
   parameter int W        = 64,
   parameter int STACK_DQ = 8
) (
   input  logic         clk,
   input  logic         rst,
   input  logic [2:0]   d_stat,
   input  logic [3:0]   d_iCode,
   input  logic [3:0]   d_iFun,
   input  logic [W-1:0] d_valA,
   input  logic [W-1:0] d_valB,
   input  logic [W-1:0] d_valC,
   input  logic [3:0]   d_dstE,
   input  logic [3:0]   d_dstM,
   input  logic         E_bubble,
   input  logic         M_bubble,
   input  logic         m_stat_bad,
   input  logic         W_stat_bad,
   output logic [3:0]   E_iCode,
   output logic [3:0]   E_dstM,
   output logic         e_Cnd,
   output logic [3:0]   e_dstE,
   output logic [W-1:0] e_valE,
   output logic [2:0]   cc,
   output logic [2:0]   M_stat,
   output logic [3:0]   M_iCode,
   output logic         M_Cnd,
   output logic [W-1:0] M_valE,
   output logic [W-1:0] M_valA,
   output logic [3:0]   M_dstE,
   output logic [3:0]   M_dstM
);

   typedef struct packed {
      logic [2:0]   stat;
      logic [3:0]   icode;
      logic [3:0]   ifun;
      logic [W-1:0] val_a;
      logic [W-1:0] val_b;
      logic [W-1:0] val_c;
      logic [3:0]   dst_e;
      logic [3:0]   dst_m;
   } e_reg_t;

   typedef struct packed {
      logic [2:0]   stat;
      logic [3:0]   icode;
      logic         cnd;
      logic [W-1:0] val_e;
      logic [W-1:0] val_a;
      logic [3:0]   dst_e;
      logic [3:0]   dst_m;
   } m_reg_t;

   localparam e_reg_t E_NOP = '{stat: STAT_AOK, icode: INOP, ifun: 4'h0, val_a: '0,
                                val_b: '0, val_c: '0, dst_e: RNONE, dst_m: RNONE};
   localparam m_reg_t M_NOP = '{stat: STAT_AOK, icode: INOP, cnd: 1'b0, val_e: '0,
                                val_a: '0, dst_e: RNONE, dst_m: RNONE};

   e_reg_t       e_q, e_d;
   m_reg_t       m_q, m_d;
   logic [2:0]   cc_q, cc_d;
   logic [W-1:0] alu_a, alu_b, alu_res;
   alu_fun_t     alu_fun;
   logic         alu_zf, alu_sf, alu_of;
   logic         op_bad, cc_upd;
   logic         zf, sf, of;

   always_comb begin
      e_d = E_NOP;
      if (!E_bubble) begin
         e_d.stat  = d_stat;
         e_d.icode = d_iCode;
         e_d.ifun  = d_iFun;
         e_d.val_a = d_valA;
         e_d.val_b = d_valB;
         e_d.val_c = d_valC;
         e_d.dst_e = d_dstE;
         e_d.dst_m = d_dstM;
      end
   end

   always_comb begin
      alu_a = '0;
      alu_b = '0;
      case (e_q.icode)
         IRRMOVQ:          alu_a = e_q.val_a;
         IIRMOVQ:          alu_a = e_q.val_c;
         IOPQ:             begin alu_a = e_q.val_a; alu_b = e_q.val_b; end
         IRMMOVQ, IMRMOVQ: begin alu_a = e_q.val_c; alu_b = e_q.val_b; end
         ICALL, IPUSHQ:    begin alu_a = '0 - W'(STACK_DQ); alu_b = e_q.val_b; end
         IRET, IPOPQ:      begin alu_a = W'(STACK_DQ); alu_b = e_q.val_b; end
         default:          alu_a = '0;
      endcase
      alu_fun = (e_q.icode == IOPQ) ? alu_fun_t'(e_q.ifun) : ALU_ADD;
   end

   y86_alu #(.W(W)) u_alu (
      .alu_a (alu_a),
      .alu_b (alu_b),
      .fun   (alu_fun),
      .res   (alu_res),
      .zf    (alu_zf),
      .sf    (alu_sf),
      .of    (alu_of)
   );

   assign op_bad = (e_q.icode == IOPQ) && (e_q.ifun > MAX_OPQ_FUN);
   assign e_valE = op_bad ? '0 : alu_res;
   assign cc_upd = (e_q.icode == IOPQ) && (e_q.stat == STAT_AOK) && !op_bad
                   && !m_stat_bad && !W_stat_bad;

   // condition is evaluated against the stored flags, not this instruction's result
   always_comb begin
      {zf, sf, of} = cc_q;
      e_Cnd = 1'b0;
      case (e_q.ifun)
         C_YES:   e_Cnd = 1'b1;
         C_LE:    e_Cnd = (sf ^ of) | zf;
         C_L:     e_Cnd = sf ^ of;
         C_E:     e_Cnd = zf;
         C_NE:    e_Cnd = !zf;
         C_GE:    e_Cnd = !(sf ^ of);
         C_G:     e_Cnd = !(sf ^ of) && !zf;
         default: e_Cnd = 1'b0;
      endcase
   end

   assign e_dstE = (e_q.icode == IRRMOVQ && !e_Cnd) ? RNONE : e_q.dst_e;
   assign cc_d   = cc_upd ? {alu_zf, alu_sf, alu_of} : cc_q;

   always_comb begin
      m_d = M_NOP;
      if (!M_bubble) begin
         m_d.stat  = (op_bad && e_q.stat == STAT_AOK) ? STAT_INS : e_q.stat;
         m_d.icode = e_q.icode;
         m_d.cnd   = e_Cnd;
         m_d.val_e = e_valE;
         m_d.val_a = e_q.val_a;
         m_d.dst_e = e_dstE;
         m_d.dst_m = e_q.dst_m;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         e_q  <= E_NOP;
         m_q  <= M_NOP;
         cc_q <= CC_RESET;
      end else begin
         e_q  <= e_d;
         m_q  <= m_d;
         cc_q <= cc_d;
      end
   end

   assign E_iCode = e_q.icode;
   assign E_dstM  = e_q.dst_m;
   assign cc      = cc_q;
   assign M_stat  = m_q.stat;
   assign M_iCode = m_q.icode;
   assign M_Cnd   = m_q.cnd;
   assign M_valE  = m_q.val_e;
   assign M_valA  = m_q.val_a;
   assign M_dstE  = m_q.dst_e;
   assign M_dstM  = m_q.dst_m;

endmodule
